alu_issue: RTL

//  Decode/issue stage feeding the combinational alu: accepts a decoded-register-read RV32I

---
 rtl/alu_issue_pkg.sv | 52 +++++
 rtl/alu_issue_decode.sv | 96 +++++++++
 rtl/alu_issue.sv | 98 +++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// Shared types for the RV32I decode/issue stage.
//   size_t      : XLEN-wide operand / pc type
//   ops         : operation selector understood by the combinational alu
//   opcode_t    : major opcodes handled by the issue stage
//   F3_* / F7_* : funct3 / funct7 field values
//   issue_pkt_t : decoded packet handed to EX
package alu_issue_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] size_t;

  typedef enum logic [3:0] {
    _add = 4'd0,
    _sub = 4'd1,
    _sll = 4'd2,
    _xor = 4'd3,
    _srl = 4'd4,
    _sra = 4'd5,
    _or  = 4'd6,
    _and = 4'd7
  } ops;

  typedef enum logic [6:0] {
    OP     = 7'b0110011,
    OP_IMM = 7'b0010011,
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111
  } opcode_t;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    ops         aluop;
    size_t      a;
    size_t      b;
    logic [4:0] rd;
    logic       we;
    logic       illegal;
  } issue_pkt_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Pure combinational RV32I decode for the alu issue stage.
// Ports:
//   instr : instruction word
//   pc    : instruction pc (AUIPC operand a)
//   rs1   : rs1 value
//   rs2   : rs2 value
//   pkt   : decoded issue packet {aluop, a, b, rd, we, illegal}
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr,
  input  size_t       pc,
  input  size_t       rs1,
  input  size_t       rs2,
  output issue_pkt_t  pkt
);

  logic [6:0]               opcode;
  logic [2:0]               funct3;
  logic [6:0]               funct7;
  logic signed [11:0]       imm_i;
  logic signed [XLEN-1:0]   imm_sext;
  logic                     is_op;
  logic                     is_shift;
  logic [4:0]               shamt;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign imm_i    = instr[31:20];
  assign imm_sext = {{(XLEN-12){imm_i[11]}}, imm_i};
  assign is_op    = (opcode == OP);

  always_comb begin
    pkt          = '0;
    pkt.aluop    = _add;
    pkt.rd       = instr[11:7];
    is_shift     = 1'b0;
    shamt        = is_op ? rs2[4:0] : instr[24:20];

    case (opcode)
      OP: begin
        pkt.a = rs1;
        pkt.b = rs2;
      end
      OP_IMM: begin
        pkt.a = rs1;
        pkt.b = size_t'(imm_sext);
      end
      LUI: begin
        pkt.a = '0;
        pkt.b = {instr[31:12], 12'b0};
      end
      AUIPC: begin
        pkt.a = pc;
        pkt.b = {instr[31:12], 12'b0};
      end
      default: pkt.illegal = 1'b1;
    endcase

    // funct3 only selects the operation for the register/immediate alu groups
    if (opcode == OP || opcode == OP_IMM) begin
      case (funct3)
        F3_ADD: pkt.aluop = (is_op && funct7 == F7_ALT) ? _sub : _add;
        F3_SLL: begin
          pkt.aluop = _sll;
          is_shift  = 1'b1;
        end
        F3_XOR: pkt.aluop = _xor;
        F3_SR: begin
          pkt.aluop = funct7[5] ? _sra : _srl;
          is_shift  = 1'b1;
        end
        F3_OR:  pkt.aluop = _or;
        F3_AND: pkt.aluop = _and;
        default: pkt.illegal = 1'b1;  // SLT/SLTU are not executed by this alu
      endcase
    end

    if (is_shift) begin
      pkt.b = {{(XLEN-5){1'b0}}, shamt};
      if (funct7 != F7_BASE && funct7 != F7_ALT)
        pkt.illegal = 1'b1;
    end

    // Illegal instructions still issue so EX can trap, but with a neutral payload
    if (pkt.illegal) begin
      pkt.aluop = _add;
      pkt.a     = '0;
      pkt.b     = '0;
    end

    pkt.we = !pkt.illegal && (pkt.rd != 5'd0);
  end

endmodule

// File: rtl/alu_issue.sv
// Decode/issue stage between regfile read and EX. Accepts a read-operand
// instruction over valid/ready, decodes it and presents a registered issue
// packet. A 2-entry skid buffer (main M + skid S) keeps in_ready a flop while
// sustaining one transfer per cycle.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   flush               : drop all held entries (branch redirect)
//   in_valid/in_ready   : upstream handshake
//   in_instr/pc/rs1/rs2 : instruction word, pc and operand values
//   out_valid/out_ready : downstream handshake
//   out_aluop/a/b/rd    : issue packet for the alu
//   out_we/out_illegal  : rd write enable, not-executable flag
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output ops              out_aluop,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [REGW-1:0] out_rd,
  output logic            out_we,
  output logic            out_illegal
);

  issue_pkt_t dec_pkt_p0;
  issue_pkt_t m_pkt_p1;
  issue_pkt_t s_pkt_p1;
  logic       m_vld_p1;
  logic       s_vld_p1;
  logic       accept;
  logic       drain;

  // ---- p0: combinational decode of the presented instruction ----
  alu_issue_decode u_decode (
    .instr (in_instr),
    .pc    (in_pc),
    .rs1   (in_rs1),
    .rs2   (in_rs2),
    .pkt   (dec_pkt_p0)
  );

  // Skid slot occupied is the only back-pressure source, so in_ready is a flop output
  assign in_ready = !s_vld_p1;
  assign accept   = in_valid && in_ready;
  assign drain    = m_vld_p1 && out_ready;

  // ---- p1: main/skid registers ----
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      m_vld_p1 <= 1'b0;
      s_vld_p1 <= 1'b0;
    end else if (drain) begin
      if (s_vld_p1) begin
        m_vld_p1 <= 1'b1;
        s_vld_p1 <= 1'b0;
      end else begin
        m_vld_p1 <= accept;
      end
    end else if (accept) begin
      if (!m_vld_p1) m_vld_p1 <= 1'b1;
      else           s_vld_p1 <= 1'b1;
    end
  end

  // Payload registers carry no reset; the valid bits qualify them
  always_ff @(posedge clk) begin
    if (drain && s_vld_p1)
      m_pkt_p1 <= s_pkt_p1;
    else if (accept && (drain || !m_vld_p1))
      m_pkt_p1 <= dec_pkt_p0;

    if (accept && m_vld_p1 && !drain)
      s_pkt_p1 <= dec_pkt_p0;
  end

  // Idle outputs show the neutral packet so reset/flush leave defined values
  assign out_valid   = m_vld_p1;
  assign out_aluop   = m_vld_p1 ? m_pkt_p1.aluop : _add;
  assign out_a       = m_vld_p1 ? m_pkt_p1.a : '0;
  assign out_b       = m_vld_p1 ? m_pkt_p1.b : '0;
  assign out_rd      = m_vld_p1 ? REGW'(m_pkt_p1.rd) : '0;
  assign out_we      = m_vld_p1 && m_pkt_p1.we;
  assign out_illegal = m_vld_p1 && m_pkt_p1.illegal;

endmodule
